// File: rtl/ctrlreg_bank.sv
// ctrlreg_bank: bank of NUM_CH double-buffered control registers.
// Host writes land in a per-channel shadow word. A commit copies every dirty
// shadow to its active word in the same cycle, so all control outputs change together.
// Optional feature macro: CTRLREG_BANK_AUTOCOMMIT_EN. When it is defined, an idle
// counter issues a commit after AUTO_CYC write-free cycles with dirty shadows pending.
module ctrlreg_bank #(
    parameter int                DATA_W   = 8,
    parameter int                NUM_CH   = 4,
    parameter int                ADDR_W   = 2,
    parameter logic [DATA_W-1:0] RST_VAL  = '0,
    parameter int                AUTO_CYC = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_CE,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_d,
    input  logic                     i_commit,
    input  logic                     i_err_clr,
    output logic [NUM_CH*DATA_W-1:0] o_q,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [NUM_CH-1:0]        o_dirty,
    output logic                     o_commit_done,
    output logic                     o_err
);

    // Per-channel write strobes. Each strobe compares i_addr only against an
    // existing channel index, so an out-of-range address never matches.
    logic [NUM_CH-1:0]        wr_hit;
    logic [NUM_CH-1:0]        dirty_flat;
    logic [NUM_CH*DATA_W-1:0] shadow_flat;
    logic                     wr_err;
    logic                     auto_fire;
    logic                     commit_fire;
    logic [DATA_W-1:0]        rd_next;
    logic [DATA_W-1:0]        rd_data_reg;
    logic                     commit_done_reg;
    logic                     err_reg;

    assign wr_err      = i_CE && !(|wr_hit);
    assign commit_fire = i_commit || auto_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [DATA_W-1:0] shadow_reg;
            logic [DATA_W-1:0] active_reg;
            logic              dirty_reg;

            assign wr_hit[gi]                          = i_CE && (i_addr == ADDR_W'(gi));
            assign shadow_flat[gi*DATA_W +: DATA_W]    = shadow_reg;
            assign o_q[gi*DATA_W +: DATA_W]            = active_reg;
            assign dirty_flat[gi]                      = dirty_reg;

            // Shadow capture, and the shadow-to-active transfer on commit.
            // The commit reads the shadow before this edge's write, so a
            // same-cycle write stays pending and keeps its dirty flag set.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    shadow_reg <= RST_VAL;
                    active_reg <= RST_VAL;
                    dirty_reg  <= 1'b0;
                end else begin
                    if (commit_fire && dirty_reg) begin
                        active_reg <= shadow_reg;
                    end
                    if (wr_hit[gi]) begin
                        shadow_reg <= i_d;
                        dirty_reg  <= 1'b1;
                    end else if (commit_fire) begin
                        dirty_reg  <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Shadow readback mux. An address with no channel behind it reads as zero.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_addr == ADDR_W'(k)) begin
                rd_next = shadow_flat[k*DATA_W +: DATA_W];
            end
        end
    end

    // Registered readback, the commit-done pulse, and the sticky error flag.
    // A new bad write takes priority over i_err_clr in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_reg     <= '0;
            commit_done_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            rd_data_reg     <= rd_next;
            commit_done_reg <= commit_fire;
            if (wr_err) begin
                err_reg <= 1'b1;
            end else if (i_err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

`ifdef CTRLREG_BANK_AUTOCOMMIT_EN
    localparam int CNT_W = $clog2(AUTO_CYC + 1);

    logic [CNT_W-1:0] idle_cnt_reg;
    logic             idle_tick;

    // An idle cycle is a cycle with no write while some shadow is pending.
    // The commit fires on the idle edge that would bring the count to AUTO_CYC.
    assign idle_tick = !i_CE && (|dirty_flat);
    assign auto_fire = idle_tick && (idle_cnt_reg == CNT_W'(AUTO_CYC - 1));

    // Idle counter. Any write or commit restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt_reg <= '0;
        end else if (i_CE || commit_fire) begin
            idle_cnt_reg <= '0;
        end else if (idle_tick) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end
`else
    // Without the auto-commit feature, commits come only from i_commit.
    // AUTO_CYC has no effect in this build.
    logic unused_auto_cyc;
    assign unused_auto_cyc = (AUTO_CYC > 0);
    assign auto_fire       = 1'b0;
`endif

    assign o_rd_data     = rd_data_reg;
    assign o_dirty       = dirty_flat;
    assign o_commit_done = commit_done_reg;
    assign o_err         = err_reg;

endmodule

// File: tb/tb_ctrlreg_bank.sv
// Bench for ctrlreg_bank (3 channels, 2-bit address, non-zero reset value).
// Directed scenarios run first, followed by a randomized run that is checked
// against a word-level reference model. The auto-commit scenario follows
// CTRLREG_BANK_AUTOCOMMIT_EN.
`timescale 1ns/1ps
module tb_ctrlreg_bank;
    localparam int          DW  = 8;
    localparam int          NCH = 3;
    localparam int          AW  = 2;
    localparam logic [7:0]  RV  = 8'h5A;
    localparam int          AC  = 4;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_CE = 1'b0;
    logic [AW-1:0]      i_addr = '0;
    logic [DW-1:0]      i_d = '0;
    logic               i_commit = 1'b0;
    logic               i_err_clr = 1'b0;
    logic [NCH*DW-1:0]  o_q;
    logic [DW-1:0]      o_rd_data;
    logic [NCH-1:0]     o_dirty;
    logic               o_commit_done;
    logic               o_err;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0] shadow_m [NCH];
    logic [7:0] active_m [NCH];
    bit         dirty_m  [NCH];
    logic [7:0] rd_m;
    bit         done_m;
    bit         err_m;
    int         idle_m;

    ctrlreg_bank #(
        .DATA_W(DW), .NUM_CH(NCH), .ADDR_W(AW), .RST_VAL(RV), .AUTO_CYC(AC)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_CE(i_CE), .i_addr(i_addr), .i_d(i_d),
        .i_commit(i_commit), .i_err_clr(i_err_clr), .o_q(o_q), .o_rd_data(o_rd_data),
        .o_dirty(o_dirty), .o_commit_done(o_commit_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            shadow_m[k] = RV;
            active_m[k] = RV;
            dirty_m[k]  = 1'b0;
        end
        rd_m = 8'h00; done_m = 1'b0; err_m = 1'b0; idle_m = 0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_edge(input bit ce, input int a, input logic [7:0] d,
                              input bit cm, input bit clr);
        bit any_dirty;
        bit auto_now;
        bit commit_now;
        any_dirty = 1'b0;
        for (int k = 0; k < NCH; k++) any_dirty |= dirty_m[k];
`ifdef CTRLREG_BANK_AUTOCOMMIT_EN
        auto_now = !ce && any_dirty && (idle_m + 1 == AC);
`else
        auto_now = 1'b0;
`endif
        commit_now = cm || auto_now;
        rd_m = (a < NCH) ? shadow_m[a] : 8'h00;
        if (commit_now) begin
            for (int k = 0; k < NCH; k++) begin
                if (dirty_m[k]) begin
                    active_m[k] = shadow_m[k];
                    dirty_m[k]  = 1'b0;
                end
            end
        end
        if (ce && a < NCH) begin
            shadow_m[a] = d;
            dirty_m[a]  = 1'b1;
        end
        if (ce && a >= NCH) err_m = 1'b1;
        else if (clr)       err_m = 1'b0;
        done_m = commit_now;
        if (ce || commit_now) idle_m = 0;
        else if (any_dirty)   idle_m = idle_m + 1;
    endtask

    function automatic logic [NCH*DW-1:0] exp_q();
        logic [NCH*DW-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*DW +: DW] = active_m[k];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_dirty();
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = dirty_m[k];
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, and sample 1ns later.
    task automatic cyc(input bit ce, input int a, input logic [7:0] d,
                       input bit cm, input bit clr);
        i_CE = ce; i_addr = AW'(a); i_d = d; i_commit = cm; i_err_clr = clr;
        @(posedge i_clk);
        model_edge(ce, a, d, cm, clr);
        #1;
    endtask

    task automatic do_reset();
        i_CE = 0; i_addr = '0; i_d = '0; i_commit = 0; i_err_clr = 0;
        i_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [NCH*DW-1:0] q0;
        do_reset();
        checks++; if (o_q !== {NCH{RV}}) begin errors++; $display("FAIL reset_q got=%h exp=%h", o_q, {NCH{RV}}); end
        checks++; if (o_dirty !== 3'b000) begin errors++; $display("FAIL reset_dirty got=%b exp=000", o_dirty); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
        checks++; if (o_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd got=%h exp=00", o_rd_data); end
        checks++; if (o_commit_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_commit_done); end
        q0 = {NCH{RV}};
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 8'h00, 0, 0);
            checks++; if (o_q !== q0) begin errors++; $display("FAIL idle_q cyc=%0d got=%h exp=%h", i, o_q, q0); end
        end
        $display("test_reset done");
    endtask

    task automatic test_write_commit();
        cyc(1, 1, 8'hA5, 0, 0);
        cyc(1, 2, 8'h3C, 0, 0);
        checks++; if (o_dirty !== 3'b110) begin errors++; $display("FAIL wr_dirty got=%b exp=110", o_dirty); end
        checks++; if (o_q !== {NCH{RV}}) begin errors++; $display("FAIL wr_q_held got=%h exp=%h", o_q, {NCH{RV}}); end
        cyc(0, 1, 8'h00, 0, 0);
        checks++; if (o_rd_data !== 8'hA5) begin errors++; $display("FAIL wr_readback got=%h exp=a5", o_rd_data); end
        cyc(0, 0, 8'h00, 1, 0);
        checks++; if (o_q !== 24'h3CA55A) begin errors++; $display("FAIL commit_q got=%h exp=3ca55a", o_q); end
        checks++; if (o_dirty !== 3'b000) begin errors++; $display("FAIL commit_dirty got=%b exp=000", o_dirty); end
        checks++; if (o_commit_done !== 1'b1) begin errors++; $display("FAIL commit_pulse got=%b exp=1", o_commit_done); end
        cyc(0, 0, 8'h00, 0, 0);
        checks++; if (o_commit_done !== 1'b0) begin errors++; $display("FAIL commit_pulse_end got=%b exp=0", o_commit_done); end
        $display("test_write_commit done");
    endtask

    task automatic test_same_cycle();
        cyc(1, 0, 8'h22, 0, 0);
        cyc(1, 0, 8'h11, 1, 0);
        checks++; if (o_q !== 24'h3CA522) begin errors++; $display("FAIL same_q got=%h exp=3ca522", o_q); end
        checks++; if (o_dirty !== 3'b001) begin errors++; $display("FAIL same_dirty got=%b exp=001", o_dirty); end
        cyc(0, 0, 8'h00, 0, 0);
        checks++; if (o_rd_data !== 8'h11) begin errors++; $display("FAIL same_shadow got=%h exp=11", o_rd_data); end
        // Readback during a same-cycle write to the same address returns the old value.
        cyc(1, 1, 8'h99, 0, 0);
        checks++; if (o_rd_data !== 8'hA5) begin errors++; $display("FAIL rd_old got=%h exp=a5", o_rd_data); end
        cyc(0, 0, 8'h00, 1, 0);
        checks++; if (o_q !== 24'h3C9911) begin errors++; $display("FAIL same_recommit got=%h exp=3c9911", o_q); end
        checks++; if (o_dirty !== 3'b000) begin errors++; $display("FAIL same_dirty_clr got=%b exp=000", o_dirty); end
        $display("test_same_cycle done");
    endtask

    task automatic test_err();
        cyc(1, 3, 8'hFF, 0, 0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", o_err); end
        checks++; if (o_q !== 24'h3C9911 || o_dirty !== 3'b000) begin errors++; $display("FAIL err_nochange q=%h dirty=%b exp=3c9911/000", o_q, o_dirty); end
        checks++; if (o_rd_data !== 8'h00) begin errors++; $display("FAIL err_rd_oor got=%h exp=00", o_rd_data); end
        cyc(0, 0, 8'h00, 0, 0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", o_err); end
        cyc(0, 0, 8'h00, 0, 1);
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b exp=0", o_err); end
        cyc(1, 3, 8'h01, 0, 1);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_clr_vs_new got=%b exp=1", o_err); end
        cyc(0, 0, 8'h00, 0, 1);
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clr2 got=%b exp=0", o_err); end
        $display("test_err done");
    endtask

    task automatic test_async_reset();
        cyc(1, 1, 8'h44, 0, 0);
        // ch2 write while committing: ch1 goes active, ch2 stays pending, done is in flight.
        cyc(1, 2, 8'hC3, 1, 0);
        checks++; if (o_dirty !== 3'b100 || o_commit_done !== 1'b1) begin errors++; $display("FAIL pre_rst dirty=%b done=%b exp=100/1", o_dirty, o_commit_done); end
        i_CE = 0; i_commit = 0;
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (o_q !== {NCH{RV}}) begin errors++; $display("FAIL async_q got=%h exp=%h", o_q, {NCH{RV}}); end
        checks++; if (o_dirty !== 3'b000 || o_commit_done !== 1'b0 || o_err !== 1'b0 || o_rd_data !== 8'h00)
            begin errors++; $display("FAIL async_flags dirty=%b done=%b err=%b rd=%h exp=000/0/0/00", o_dirty, o_commit_done, o_err, o_rd_data); end
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2, 8'h00, 0, 0);
            checks++; if (o_commit_done !== 1'b0 || o_dirty !== 3'b000 || o_rd_data !== RV)
                begin errors++; $display("FAIL post_rst cyc=%0d done=%b dirty=%b rd=%h exp=0/000/%h", i, o_commit_done, o_dirty, o_rd_data, RV); end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_auto();
        do_reset();
`ifdef CTRLREG_BANK_AUTOCOMMIT_EN
        cyc(1, 0, 8'h7E, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 8'h00, 0, 0);
            if (i < 4) begin
                checks++; if (o_q[7:0] !== RV || o_commit_done !== 1'b0) begin errors++; $display("FAIL auto_early idle=%0d q0=%h done=%b exp=%h/0", i, o_q[7:0], o_commit_done, RV); end
            end else begin
                checks++; if (o_q[7:0] !== 8'h7E || o_commit_done !== 1'b1) begin errors++; $display("FAIL auto_fire q0=%h done=%b exp=7e/1", o_q[7:0], o_commit_done); end
            end
        end
        cyc(0, 0, 8'h00, 0, 0);
        checks++; if (o_commit_done !== 1'b0) begin errors++; $display("FAIL auto_pulse_end got=%b exp=0", o_commit_done); end
        cyc(1, 0, 8'h42, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(1, 0, 8'h43, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 8'h00, 0, 0);
            if (i < 4) begin
                checks++; if (o_q[7:0] !== 8'h7E) begin errors++; $display("FAIL auto_restart idle=%0d q0=%h exp=7e", i, o_q[7:0]); end
            end else begin
                checks++; if (o_q[7:0] !== 8'h43 || o_commit_done !== 1'b1) begin errors++; $display("FAIL auto_restart_fire q0=%h done=%b exp=43/1", o_q[7:0], o_commit_done); end
            end
        end
`else
        cyc(1, 0, 8'h7E, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 8'h00, 0, 0);
            checks++; if (o_q[7:0] !== RV || o_dirty !== 3'b001 || o_commit_done !== 1'b0)
                begin errors++; $display("FAIL no_auto cyc=%0d q0=%h dirty=%b done=%b exp=%h/001/0", i, o_q[7:0], o_dirty, o_commit_done, RV); end
        end
`endif
        $display("test_auto done");
    endtask

    task automatic test_random();
        bit ce, cm, clr;
        int a;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            ce  = ($urandom_range(0, 2) == 0);
            cm  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 7) == 0);
            a   = $urandom_range(0, 3);
            d   = 8'($urandom);
            cyc(ce, a, d, cm, clr);
            checks++; if (o_q !== exp_q()) begin errors++; $display("FAIL rnd_q cyc=%0d got=%h exp=%h", i, o_q, exp_q()); end
            checks++; if (o_dirty !== exp_dirty()) begin errors++; $display("FAIL rnd_dirty cyc=%0d got=%b exp=%b", i, o_dirty, exp_dirty()); end
            checks++; if (o_rd_data !== rd_m) begin errors++; $display("FAIL rnd_rd cyc=%0d got=%h exp=%h", i, o_rd_data, rd_m); end
            checks++; if (o_commit_done !== done_m) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, o_commit_done, done_m); end
            checks++; if (o_err !== err_m) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, o_err, err_m); end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_same_cycle();
        test_err();
        test_async_reset();
        test_auto();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
